// File: rtl/fm_cmn_bram_fifo_00_pkg.sv
// Shared types for the BRAM-backed first-word-fall-through FIFO.
// Classifies each cycle's push/pop pair into a level-counter operation.
package fm_cmn_bram_fifo_00_pkg;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

    function automatic lvl_op_e lvl_op(input logic push, input logic pop);
        if (push && !pop) begin
            return LVL_INC;
        end else if (pop && !push) begin
            return LVL_DEC;
        end
        return LVL_HOLD;
    endfunction

endpackage

// File: rtl/fm_cmn_bram_fifo_00_if.sv
// Stream bundle between a FIFO user (master) and the FIFO controller (slave).
interface fm_cmn_bram_fifo_00_if #(
    parameter int P_WIDTH = 32,
    parameter int P_RANGE = 4
);
    // A word moves on a rising edge when valid and ready are both high and
    // i_flush is low; valid never waits for ready, ready never waits for valid.
    logic               i_flush;
    logic               i_wr_valid;
    logic               o_wr_ready;
    logic [P_WIDTH-1:0] i_wr_data;
    logic               o_rd_valid;
    logic               i_rd_ready;
    logic [P_WIDTH-1:0] o_rd_data;
    logic [P_RANGE:0]   o_level;
    logic               o_afull;

    modport master (
        output i_flush, i_wr_valid, i_wr_data, i_rd_ready,
        input  o_wr_ready, o_rd_valid, o_rd_data, o_level, o_afull
    );

    modport slave (
        input  i_flush, i_wr_valid, i_wr_data, i_rd_ready,
        output o_wr_ready, o_rd_valid, o_rd_data, o_level, o_afull
    );

endinterface

// File: rtl/fm_cmn_bram_00.sv
// Simple dual-port RAM: synchronous write on port a, registered read address
// on port dpra, so dpo shows a same-edge write to that address (write-through).
module fm_cmn_bram_00 #(
    parameter int P_WIDTH = 32,
    parameter int P_RANGE = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [P_RANGE-1:0] a,
    input  logic [P_WIDTH-1:0] di,
    input  logic [P_RANGE-1:0] dpra,
    output logic [P_WIDTH-1:0] dpo
);

    logic [P_WIDTH-1:0] mem [1<<P_RANGE];
    logic [P_RANGE-1:0] dpra_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= di;
        end
        dpra_q <= dpra;
    end

    assign dpo = mem[dpra_q];

endmodule

// File: rtl/fm_cmn_bram_fifo_00.sv
// First-word-fall-through FIFO controller around fm_cmn_bram_00: the read
// address is steered one entry ahead on a pop so the next head is ready on dpo.
module fm_cmn_bram_fifo_00
    import fm_cmn_bram_fifo_00_pkg::*;
#(
    parameter int P_WIDTH    = 32,
    parameter int P_RANGE    = 4,
    parameter int P_DEPTH    = 1 << P_RANGE,
    parameter int P_AFULL_TH = P_DEPTH - 2
) (
    input  logic                 clk_core,
    input  logic                 rst,
    fm_cmn_bram_fifo_00_if.slave bus
);

    localparam logic [P_RANGE:0] L_DEPTH = P_DEPTH[P_RANGE:0];
    localparam logic [P_RANGE:0] L_AFULL = P_AFULL_TH[P_RANGE:0];

    logic [P_RANGE-1:0] wr_ptr;
    logic [P_RANGE-1:0] rd_ptr;
    logic [P_RANGE-1:0] dpra;
    logic [P_RANGE:0]   level;
    logic [P_RANGE:0]   level_next;
    logic               afull;
    logic               full;
    logic               push;
    logic               pop;
    lvl_op_e            op;

    // No pass-through when full: ready only reopens the cycle after a pop.
    assign full           = (level == L_DEPTH);
    assign bus.o_wr_ready = !full;
    assign bus.o_rd_valid = (level != '0);
    assign bus.o_level    = level;
    assign bus.o_afull    = afull;

    assign push = bus.i_wr_valid && !full && !bus.i_flush;
    assign pop  = bus.o_rd_valid && bus.i_rd_ready && !bus.i_flush;
    assign op   = lvl_op(push, pop);

    always_comb begin
        level_next = level;
        unique case (op)
            LVL_INC: level_next = level + 1'b1;
            LVL_DEC: level_next = level - 1'b1;
            default: level_next = level;
        endcase
        if (bus.i_flush) begin
            level_next = '0;
        end
    end

    always_comb begin
        dpra = rd_ptr;
        if (bus.i_flush) begin
            dpra = '0;
        end else if (pop) begin
            dpra = rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            afull  <= 1'b0;
        end else if (bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            afull  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            afull <= (level_next >= L_AFULL);
        end
    end

    fm_cmn_bram_00 #(
        .P_WIDTH (P_WIDTH),
        .P_RANGE (P_RANGE)
    ) u_bram (
        .clk  (clk_core),
        .we   (push),
        .a    (wr_ptr),
        .di   (bus.i_wr_data),
        .dpra (dpra),
        .dpo  (bus.o_rd_data)
    );

endmodule
